// File: rtl/tick_sched_pkg.sv
// Package: tick_sched_pkg
// Shared types and helpers for the tick scheduler.
//   state_t  : scheduler FSM state (IDLE, RUN)
//   sat_max  : largest value an unsigned counter of the given width can hold
package tick_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Saturation ceiling for a width-bit unsigned counter (all ones).
    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Module: edge_sync
// Synchronizes an asynchronous level into the clk domain and emits a registered
// one-cycle pulse for every synchronized 0->1 transition.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous, active-high reset (clears chain, history and pulse)
//   din  in  asynchronous level (prescaled clock)
//   tick out registered pulse, high for one clk per rising edge of din
module edge_sync #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: every flop here uses <= so the chain shifts by exactly one stage per
    // clock; blocking assignments would collapse the stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            // prev_q resets low, so a level already high at reset release
            // still produces one tick.
            tick   <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Module: tick_scheduler
// Turns rising edges of the prescaled clock into ticks, counts ticks down from a
// programmable interval and raises an event (valid/ready) on expiry. One-shot or
// periodic; events that arrive while one is still pending are counted as misses.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   slow_clk_in  prescaler output, sampled as asynchronous data
//   enable       1 = ticks decrement the counter, 0 = counter and state frozen
//   periodic     1 = reload on expiry, 0 = return to IDLE
//   interval     ticks per event, sampled on start and on each periodic reload
//   start        load interval and (re)enter RUN
//   evt_ready    consumer accepts the pending event
//   clr_miss     clear miss_cnt (wins over a same-cycle increment)
//   evt_valid    event pending
//   tick         one-cycle pulse per synchronized rising edge
//   busy         scheduler is in RUN
//   count        remaining ticks (0 in IDLE)
//   miss_cnt     saturating count of events lost to backpressure
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slow_clk_in,
    input  logic              enable,
    input  logic              periodic,
    input  logic [CNT_W-1:0]  interval,
    input  logic              start,
    input  logic              evt_ready,
    input  logic              clr_miss,
    output logic              evt_valid,
    output logic              tick,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(sat_max(MISS_W));

    state_t state;
    logic   expire;
    logic   miss_inc;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (slow_clk_in),
        .tick (tick)
    );

    // A start in the same cycle as the final tick reloads instead of expiring.
    assign expire   = (state == RUN) && tick && enable && !start
                      && (count == CNT_W'(1));
    assign miss_inc = expire && evt_valid && !evt_ready;
    assign busy     = (state == RUN);

    // Scheduler FSM and countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && interval != '0) begin
                        state <= RUN;
                        count <= interval;
                    end
                end
                RUN: begin
                    if (start) begin
                        if (interval == '0) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= interval;
                        end
                    end else if (tick && enable) begin
                        if (count > CNT_W'(1)) begin
                            count <= count - CNT_W'(1);
                        end else if (periodic && interval != '0) begin
                            count <= interval;
                        end else begin
                            state <= IDLE;
                            count <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Event handshake and miss counter. A new expiry keeps evt_valid high even
    // when the previous event is accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            if (expire) begin
                evt_valid <= 1'b1;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (clr_miss) begin
                miss_cnt <= '0;
            end else if (miss_inc && miss_cnt != MISS_MAX) begin
                miss_cnt <= miss_cnt + MISS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench: tb_tick_scheduler
// Drives directed phases followed by randomized traffic into two scheduler
// instances (MISS_W=4 and MISS_W=2) sharing the same stimulus. A reference model
// predicts every cycle's outputs; predictions are queued by the driver and
// popped by an independent monitor on the falling edge.
module tb_tick_scheduler;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int LIMIT = 600;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             slow_clk_in = 1'b0;
    logic             enable = 1'b1;
    logic             periodic = 1'b0;
    logic [CNT_W-1:0] interval = '0;
    logic             start = 1'b0;
    logic             evt_ready = 1'b0;
    logic             clr_miss = 1'b0;

    logic             evt_valid, tick, busy;
    logic [CNT_W-1:0] count;
    logic [3:0]       miss_cnt;
    logic             evt_valid2, tick2, busy2;
    logic [CNT_W-1:0] count2;
    logic [1:0]       miss_cnt2;

    always #5 clk = ~clk;

    tick_scheduler #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MISS_W(4)) u_dut (
        .clk(clk), .rst(rst), .slow_clk_in(slow_clk_in), .enable(enable),
        .periodic(periodic), .interval(interval), .start(start),
        .evt_ready(evt_ready), .clr_miss(clr_miss), .evt_valid(evt_valid),
        .tick(tick), .busy(busy), .count(count), .miss_cnt(miss_cnt)
    );

    tick_scheduler #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MISS_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .slow_clk_in(slow_clk_in), .enable(enable),
        .periodic(periodic), .interval(interval), .start(start),
        .evt_ready(evt_ready), .clr_miss(clr_miss), .evt_valid(evt_valid2),
        .tick(tick2), .busy(busy2), .count(count2), .miss_cnt(miss_cnt2)
    );

    typedef struct {
        bit tick;
        bit busy;
        bit evt;
        int count;
        int miss;
        int miss2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // ---------------- reference model ----------------
    bit hist [SYNC+2];   // hist[j] = slow_clk_in sampled j edges ago
    bit m_tick, m_run, m_pend;
    int m_rem, m_miss, m_miss2, m_exp_cnt;
    bit slow_rand;
    int div_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL timeout %s at %0t: condition not reached in %0d cycles", nm, $time, LIMIT);
    endtask

    // Applies the spec rules for one clock edge using the inputs now on the pins.
    task automatic model_step();
        bit nt, expire, inc;
        expire = 1'b0;
        inc    = 1'b0;
        nt     = 1'b0;
        if (rst) begin
            foreach (hist[i]) hist[i] = 1'b0;
            m_run = 1'b0; m_rem = 0; m_pend = 1'b0; m_miss = 0; m_miss2 = 0;
        end else begin
            for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = slow_clk_in;
            nt = hist[SYNC] & ~hist[SYNC+1];
            if (start) begin
                m_run = (interval != 0);
                m_rem = int'(interval);
            end else if (m_run && m_tick && enable) begin
                if (m_rem > 1) begin
                    m_rem--;
                end else begin
                    expire = 1'b1;
                    m_exp_cnt++;
                    if (periodic && interval != 0) m_rem = int'(interval);
                    else begin
                        m_run = 1'b0;
                        m_rem = 0;
                    end
                end
            end
            if (expire) begin
                inc    = m_pend && !evt_ready;
                m_pend = 1'b1;
            end else if (evt_ready) begin
                m_pend = 1'b0;
            end
            if (clr_miss) begin
                m_miss = 0; m_miss2 = 0;
            end else if (inc) begin
                if (m_miss < 15) m_miss++;
                if (m_miss2 < 3) m_miss2++;
            end
        end
        m_tick = nt;
    endtask

    // One clock: predict, let the edge happen, queue the prediction.
    task automatic cycle();
        exp_t e;
        if (!slow_rand) slow_clk_in = div_cnt[3];
        div_cnt++;
        model_step();
        @(posedge clk);
        e.tick = m_tick; e.busy = m_run; e.evt = m_pend;
        e.count = m_rem; e.miss = m_miss; e.miss2 = m_miss2;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick",      tick,       e.tick);
                check("busy",      busy,       e.busy);
                check("count",     count,      e.count);
                check("evt_valid", evt_valid,  e.evt);
                check("miss_cnt",  miss_cnt,   e.miss);
                check("tick_w2",   tick2,      e.tick);
                check("busy_w2",   busy2,      e.busy);
                check("count_w2",  count2,     e.count);
                check("evt_w2",    evt_valid2, e.evt);
                check("miss_w2",   miss_cnt2,  e.miss2);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        int n;
        slow_rand = 1'b0;
        div_cnt   = 0;
        m_exp_cnt = 0;
        foreach (hist[i]) hist[i] = 1'b0;
        m_tick = 0; m_run = 0; m_pend = 0; m_rem = 0; m_miss = 0; m_miss2 = 0;

        // 1. reset with the slow clock running, then idle ticking
        rst = 1'b1;
        cycles(5);
        rst = 1'b0;
        cycles(40);

        // 2. one-shot, interval 3, always ready
        evt_ready = 1'b1; periodic = 1'b0; interval = 8'd3;
        start = 1'b1; cycle(); start = 1'b0;
        cycles(3 * 16 + 10);
        #3;
        check("oneshot_busy", busy, 0);
        check("oneshot_count", count, 0);

        // 3. periodic, interval 2, no accepts: misses accumulate and saturate
        evt_ready = 1'b0; periodic = 1'b1; interval = 8'd2; m_exp_cnt = 0;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (m_exp_cnt < 5 && n < LIMIT) begin cycle(); n++; end
        if (n >= LIMIT) timeout("five_expiries");
        #3;
        check("miss_after_5", miss_cnt, 4);
        check("evt_held", evt_valid, 1);
        n = 0;
        while (m_exp_cnt < 7 && n < LIMIT) begin cycle(); n++; end
        if (n >= LIMIT) timeout("seven_expiries");
        #3;
        check("miss_w2_sat", miss_cnt2, 3);
        // clear coinciding with an expiry
        n = 0;
        while (!(m_run && m_tick && enable && m_rem == 1) && n < LIMIT) begin cycle(); n++; end
        if (n >= LIMIT) timeout("clr_expiry");
        clr_miss = 1'b1; cycle(); clr_miss = 1'b0;
        #3;
        check("clr_beats_inc", miss_cnt, 0);
        evt_ready = 1'b1;
        cycles(3);

        // 4. periodic, interval 4, freeze at count 2 for ~10 ticks
        interval = 8'd4;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (m_rem != 2 && n < LIMIT) begin cycle(); n++; end
        if (n >= LIMIT) timeout("count_two");
        enable = 1'b0;
        cycles(160);
        #3;
        check("frozen_count", count, 2);
        enable = 1'b1;
        cycles(40);
        // start with interval 0 stops a run, and is ignored in IDLE
        interval = 8'd0;
        start = 1'b1; cycle(); start = 1'b0;
        cycles(2);
        start = 1'b1; cycle(); start = 1'b0;
        cycles(2);
        #3;
        check("zero_start_idle", busy, 0);

        // 5. start collides with the final tick: reload wins, no event
        interval = 8'd2; periodic = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (!(m_run && m_rem == 1 && m_tick) && n < LIMIT) begin cycle(); n++; end
        if (n >= LIMIT) timeout("start_on_tick");
        interval = 8'd5;
        start = 1'b1; cycle(); start = 1'b0;
        #3;
        check("reload_count", count, 5);
        check("reload_no_evt", evt_valid, 0);
        // reset while an event is pending
        evt_ready = 1'b0; periodic = 1'b1; interval = 8'd1;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (!m_pend && n < LIMIT) begin cycle(); n++; end
        if (n >= LIMIT) timeout("pending_evt");
        rst = 1'b1; cycle(); rst = 1'b0;
        #3;
        check("rst_drop_evt", evt_valid, 0);
        check("rst_busy", busy, 0);
        cycles(10);

        // randomized traffic
        slow_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5, 0) == 0) slow_clk_in = ~slow_clk_in;
            rst       = ($urandom_range(399, 0) == 0);
            start     = ($urandom_range(39, 0) == 0);
            if (start) begin
                interval = 8'($urandom_range(4, 0));
                periodic = 1'($urandom_range(1, 0));
            end
            enable    = ($urandom_range(7, 0) != 0);
            evt_ready = 1'($urandom_range(1, 0));
            clr_miss  = ($urandom_range(59, 0) == 0);
            cycle();
        end
        rst = 1'b0; start = 1'b0; clr_miss = 1'b0;

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
